// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART types and constants (receiver, transmitter, tick gen)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default number of baud ticks per bit period
  localparam int unsigned UART_OVERSAMPLE = 16;

  // Receiver FSM states; unused encodings recover to IDLE
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync
//  Brief    : Flop-chain synchroniser for the asynchronous rx line; every
//             stage resets to 1 so a reset never looks like a start bit.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw line into the bottom of the chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  end

  // Synchroniser register chain, idle-high reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_os
//  Brief    : Oversampling 8N1 UART receiver. Validates the start bit at
//             mid-bit, samples data LSB-first at bit centres, checks the stop
//             bit and reports either rx_done or frame_err for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned          c_tick_w    = $clog2(OVERSAMPLE);
  localparam logic [c_tick_w-1:0]  c_tick_mid  = c_tick_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_tick_w-1:0]  c_tick_last = c_tick_w'(OVERSAMPLE - 1);

  logic                rx_s;

  uart_state_e         state_d,     state_q;
  logic [c_tick_w-1:0] tick_cnt_d,  tick_cnt_q;
  logic [2:0]          bit_cnt_d,   bit_cnt_q;
  logic [7:0]          shift_d,     shift_q;
  logic [7:0]          rx_data_d,   rx_data_q;
  logic                rx_done_d,   rx_done_q;
  logic                frame_err_d, frame_err_q;
  logic                rx_busy_d,   rx_busy_q;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  // Next-state, counter, shifter and output-pulse logic
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A low line is enough to start; the start bit is confirmed mid-bit
        if (!rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end

      START: begin
        if (baud_tick) begin
          if (tick_cnt_q == c_tick_mid) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = 3'd0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (tick_cnt_q == c_tick_last) begin
            // Right shift: first received bit ends up in bit 0
            shift_d    = {rx_s, shift_q[7:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (tick_cnt_q == c_tick_last) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              rx_data_d = shift_q;
              rx_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      WAIT_HIGH: begin
        // Hold off while the line is broken or stuck low
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = 3'd0;
      end
    endcase

    // Busy reflects the state being entered so it drops with the pulse
    rx_busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule : uart_rx_os
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_os
//  Brief    : Self-checking bench for uart_rx_os: a behavioural 8N1 line
//             driver feeds frames, and an event queue holds the expected
//             outcome (byte or framing error) of each frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

  localparam int OS   = 16;
  localparam int SYNC = 2;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx        = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  uart_rx_os #(
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // Baud tick generator: one pulse every tick_period clocks
  int tick_period = 4;
  int div_cnt     = 0;
  always @(negedge clk) begin
    if (div_cnt >= tick_period - 1) begin
      div_cnt   = 0;
      baud_tick = 1'b1;
    end else begin
      div_cnt   = div_cnt + 1;
      baud_tick = 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         timed;
    int         t0;
    int         period;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         n_done    = 0;
  int         n_ferr    = 0;
  logic [7:0] last_good = 8'h00;
  bit         prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output pulse with the oldest outstanding frame
  task automatic monitor_step();
    exp_t e;
    int   lat;
    int   ctr;
    if (!rst) last_good = 8'h00;
    if (rx_done || frame_err) begin
      check("busy_at_pulse", {31'd0, rx_busy}, 32'd0);
      check("pulse_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
      if (rx_done) begin
        n_done++;
        check("done_width", {31'd0, prev_done}, 32'd0);
      end
      if (frame_err) n_ferr++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
        if (e.is_err) begin
          check("rx_data_held", {24'd0, rx_data}, {24'd0, last_good});
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          last_good = e.data;
        end
        if (e.timed) begin
          ctr = SYNC + (OS / 2 + 9 * OS) * e.period;
          lat = cyc - e.t0;
          check("latency",
                (lat >= ctr - e.period - 2 && lat <= ctr + e.period + 2) ? ctr : lat,
                ctr);
        end
      end
    end
    prev_done = rx_done;
  endtask

  task automatic drive(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Behavioural 8N1 transmitter; records the expected outcome first
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bp, input bit timed);
    exp_t e;
    e.is_err = !stop;
    e.data   = d;
    e.timed  = timed;
    e.t0     = cyc;
    e.period = tick_period;
    exp_q.push_back(e);
    drive(1'b0, bp);
    for (int i = 0; i < 8; i++) drive(d[i], bp);
    drive(stop, bp);
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 4000) begin
      @(negedge clk);
      b++;
    end
    check("drain", exp_q.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  int         bp;
  logic [7:0] v;
  int         sk;

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    bp = OS * tick_period;

    // First frame
    send_frame(8'hA5, 1'b1, bp, 1'b1);
    drive(1'b1, bp);
    drain();

    // Data extremes, back-to-back
    send_frame(8'h00, 1'b1, bp, 1'b1);
    send_frame(8'hFF, 1'b1, bp, 1'b1);
    drive(1'b1, bp);
    drain();

    // Start glitch of 4 ticks
    drive(1'b0, 4 * tick_period);
    check("busy_in_glitch", {31'd0, rx_busy}, 32'd1);
    drive(1'b1, OS * tick_period);
    check("busy_after_glitch", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h3C, 1'b1, bp, 1'b1);
    drive(1'b1, bp);
    drain();

    // Framing error followed by a break
    send_frame(8'h55, 1'b0, bp, 1'b1);
    drive(1'b0, 3 * bp);
    drive(1'b1, 2 * bp);
    drain();
    send_frame(8'h81, 1'b1, bp, 1'b1);
    drive(1'b1, bp);
    drain();

    // Reset in the middle of data bit 4
    v = 8'hC3;
    drive(1'b0, bp);
    for (int i = 0; i < 4; i++) drive(v[i], bp);
    drive(v[4], bp / 2);
    check("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rx_data_after_reset", {24'd0, rx_data}, 32'd0);
    check("busy_after_reset", {31'd0, rx_busy}, 32'd0);
    drive(1'b1, bp);
    send_frame(8'h7E, 1'b1, bp, 1'b1);
    drive(1'b1, bp);
    drain();

    // Loopback sweep 0x00..0xFF, transmitter bit = 16 receiver ticks
    tick_period = 1;
    repeat (4) @(negedge clk);
    bp = OS * tick_period;
    for (int i = 0; i < 256; i++) send_frame(i[7:0], 1'b1, bp, 1'b1);
    drive(1'b1, bp);
    drain();

    // Rate-skewed run, +/-3% bit period with random gaps
    tick_period = 4;
    repeat (4) @(negedge clk);
    bp = OS * tick_period;
    for (int k = 0; k < 24; k++) begin
      sk = ($urandom_range(0, 1) == 1) ? 2 : -2;
      send_frame(8'($urandom), 1'b1, bp + sk, 1'b0);
      drive(1'b1, $urandom_range(0, bp / 2));
    end
    drive(1'b1, bp);
    drain();

    check("done_count", n_done, 32'd286);
    check("ferr_count", n_ferr, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_uart_rx_os
`default_nettype wire

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver; the serial-line consumer of the team's 8N1 UART transmitter and the counterpart in the TX/RX loopback. It synchronises the asynchronous `rx` line, validates the start bit at mid-bit, samples 8 data bits LSB-first at bit centres, and checks the stop bit. Each frame produces either a one-cycle `rx_done` pulse with the byte or a one-cycle `frame_err` pulse. Timing is taken from a shared baud tick generator running at OVERSAMPLE× the bit rate.

## Interface
- OVERSAMPLE, 16, baud_tick pulses per bit; power of two, ≥8
- SYNC_STAGES, 2, synchroniser flops on `rx`; ≥2
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted at 0, sampled on `clk` rising edge)
- baud_tick  in  1  one-`clk` pulse at OVERSAMPLE× bit rate
- rx  in  1  asynchronous serial line, idle high
- rx_data  out  8  last correctly received byte; held until the next good frame
- rx_done  out  1  one-cycle pulse, `rx_data` valid from this cycle
- frame_err  out  1  one-cycle pulse, stop bit sampled low
- rx_busy  out  1  high in START, DATA, STOP

## Operation
- `rx` passes through SYNC_STAGES flops (reset value 1) → `rx_s`. All FSM decisions use `rx_s` only.
- tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is 3 bits; shift register is 8 bits. All advance only on `baud_tick`.
- IDLE: `rx_s==0` (no tick required) → START, tick_cnt=0.
- START: count ticks. At tick_cnt==OVERSAMPLE/2-1 on a tick:
  - `rx_s==1` → IDLE (glitch rejected, no pulse).
  - else → DATA, tick_cnt=0, bit_cnt=0.
- DATA: on the tick where tick_cnt==OVERSAMPLE-1, shift `rx_s` in at the MSB (right shift; LSB-first), tick_cnt=0, bit_cnt++. Sampling bit 7 (bit_cnt==7) → STOP.
- STOP: on the tick where tick_cnt==OVERSAMPLE-1, sample `rx_s`:
  - 1 → load `rx_data` from shifter, pulse `rx_done`, → IDLE.
  - 0 → pulse `frame_err`, `rx_data` unchanged, → WAIT_HIGH.
- WAIT_HIGH: break/stuck-low guard. Stay until `rx_s==1`, then → IDLE.
- Undefined state encodings → IDLE, counters cleared.
- Reset values: `rx_data`=0x00, `rx_done`=0, `frame_err`=0, `rx_busy`=0, state IDLE, counters 0, shifter 0.

## Timing
- All outputs are registered. `rx_done`/`frame_err` assert the `clk` cycle after the stop-sampling tick, for exactly one cycle.
- `rx_busy` goes high the cycle after IDLE→START and low in the same cycle the pulse asserts.
- Frame latency, start falling edge at `rx` → pulse: SYNC_STAGES clk + (OVERSAMPLE/2 + 9·OVERSAMPLE) ticks ±1 tick (start edge quantisation), i.e. ~9.5 bit times.
- Because STOP is sampled mid-bit, the receiver is back in IDLE half a bit early. A back-to-back start bit from the transmitter is caught with no lost frame.
- Reset mid-frame: frame is abandoned, no pulse, `rx_data` cleared to 0x00. Reset has priority over a coincident `baud_tick`.
- A `baud_tick` with no state change (IDLE, WAIT_HIGH) has no effect.
- Tolerance: correct reception for ±3% baud mismatch at OVERSAMPLE=16.

## Structure
- Shared package `uart_pkg`: FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH) and default OVERSAMPLE constant. The transmitter and tick generator use the same package.
- One sub-module: `uart_rx_sync` (parameterised SYNC_STAGES flop chain, reset-to-1). Everything else is in `uart_rx_os`.

## Test plan
- Reset sequence: hold `rst`=0 for 5 clk with `rx`=1 → all outputs 0, `rx_busy`=0. Then send 0xA5 at OVERSAMPLE=16 → one `rx_done`, `rx_data`=0xA5, `frame_err` never high.
- Data-bit extremes: frames 0x00 then 0xFF, back-to-back with 1 stop bit → two `rx_done` pulses, values 0x00, 0xFF.
- Start glitch: drive `rx` low for 4 ticks, then high → no pulse; `rx_busy` drops; the next frame 0x3C is received correctly.
- Framing error then break: send 0x55 with stop=0, hold `rx` low 3 bit times, release → one `frame_err`, `rx_data` keeps the previous value, no further pulses until a new valid frame 0x81 → `rx_done`, 0x81.
- Reset mid-frame: assert `rst` during data bit 4 of 0xC3 → no pulse, `rx_data`=0x00. The following frame 0x7E is received.
- Loopback: the team's UART transmitter drives `rx` from the same tick generator (tx tick = every 16th rx tick), sending 0x00–0xFF sequentially, plus a ±3% rate-skewed run → 256 `rx_done` pulses in order, zero `frame_err`.
